stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001: Parameter TICK_DIV, default 100000000, clk cycles per second (minimum 2).
REQ-002: Parameter SEC_MAX, default 59, terminal seconds value.
REQ-003: clk  input  1  single clock; all logic on its rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: start_stop  input  1  single-cycle synchronous pulse (pre-debounced) that toggles run/pause.
REQ-006: clear  input  1  single-cycle synchronous pulse that returns the stopwatch to zero.
REQ-007: seconds  output  6  current seconds value, 0..SEC_MAX.
REQ-008: sec_tick  output  1  registered one-cycle pulse on every seconds increment.
REQ-009: min_en  output  1  registered one-cycle increment-enable for the minutes counter.
REQ-010: min_clr  output  1  registered one-cycle synchronous clear for the minutes counter.
REQ-011: running  output  1  high while state is RUNNING.

Function
REQ-012: The FSM SHALL have exactly three states: IDLE, RUNNING and PAUSED.
REQ-013: IDLE SHALL hold the prescaler and seconds at 0; start_stop SHALL go to RUNNING; clear SHALL stay in IDLE and pulse min_clr.
REQ-014: RUNNING SHALL increment the prescaler every cycle; start_stop SHALL go to PAUSED; clear SHALL go to IDLE.
REQ-015: PAUSED SHALL hold the prescaler and seconds unchanged; start_stop SHALL go to RUNNING; clear SHALL go to IDLE.
REQ-016: Clear SHALL have priority over start_stop when both are high in the same cycle.
REQ-017: In RUNNING, a prescaler value of TICK_DIV-1 SHALL wrap the prescaler to 0 and increment seconds, with sec_tick high in the following cycle.
REQ-018: A seconds increment from SEC_MAX SHALL wrap seconds to 0 and assert min_en in the following cycle, coincident with sec_tick.
REQ-019: Every clear SHALL zero seconds and the prescaler at the next edge and assert min_clr for exactly one cycle, starting in the following cycle.
REQ-020: A clear in the same cycle as a prescaler terminal count SHALL suppress sec_tick and min_en.
REQ-021: min_en and min_clr SHALL never be high in the same cycle.
REQ-022: The pause/resume path SHALL neither drop nor add cycles: the prescaler resumes from its held value.
REQ-023: running SHALL be a registered decode of the RUNNING state, with no added latency relative to the state register.
REQ-024: The prescaler width SHALL be clog2(TICK_DIV); all counter arithmetic SHALL be unsigned, with no overflow beyond the terminal values.

Reset
REQ-025: rst high SHALL immediately force state IDLE, prescaler 0, seconds 0, and sec_tick, min_en, min_clr and running all 0.
REQ-026: Reset asserted mid-count SHALL discard the prescaler and seconds state and generate no min_clr pulse.
REQ-027: The first start_stop after rst is released SHALL be accepted on the first clock edge.

Structure
REQ-028: Shared package stopwatch_pkg SHALL hold the state encoding constants (IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2) and the SEC_MAX default.
REQ-029: The prescaler SHALL be a separate sub-module named tick_prescaler, with inputs en and clr and a terminal-count output.
REQ-030: The top level SHALL contain the FSM, the seconds counter and the output registers; min_en and min_clr SHALL connect directly to the minutes counter's en and clr.

Verification (TICK_DIV=4, SEC_MAX=59)
REQ-031: Apply rst, then start_stop -> running=1 next cycle; sec_tick every 4 cycles; seconds counts 1,2,3...
REQ-032: Run to seconds=59, then the next terminal count -> seconds=0, with min_en and sec_tick high for exactly one cycle.
REQ-033: Issue start_stop at prescaler=2, wait 10 cycles, then start_stop again -> seconds unchanged while paused; next sec_tick 2 cycles after resume.
REQ-034: Assert clear and start_stop together while RUNNING at seconds=30 -> state IDLE, seconds=0, min_clr one cycle, running=0.
REQ-035: Assert clear on the terminal-count cycle at seconds=59 -> no min_en, min_clr=1, seconds=0.
REQ-036: Assert rst mid-count at seconds=17 -> all outputs 0 asynchronously, with no min_clr pulse after rst is released.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: FSM encoding, seconds width
// and the default terminal seconds value.
package stopwatch_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_e;

    localparam int SEC_W           = 6;
    localparam int SEC_MAX_DEFAULT = 59;
endpackage

// File: rtl/stopwatch_if.sv
// Control/status bundle between the stopwatch controller (slave) and whoever
// drives the buttons and consumes the seconds/minutes strobes (master).
interface stopwatch_if
    import stopwatch_pkg::*;
;
    logic             start_stop;
    logic             clear;
    logic [SEC_W-1:0] seconds;
    logic             sec_tick;
    logic             min_en;
    logic             min_clr;
    logic             running;

    modport master (
        output start_stop, clear,
        input  seconds, sec_tick, min_en, min_clr, running
    );

    modport slave (
        input  start_stop, clear,
        output seconds, sec_tick, min_en, min_clr, running
    );
endinterface

// File: rtl/stopwatch_tick_prescaler.sv
// Divides clk down to one terminal-count cycle per TICK_DIV enabled cycles.
// clr wins over en; tc_o is combinational and only valid while en is high.
module tick_prescaler #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc_o
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] TERM = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = en && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/clear FSM, seconds counter and registered
// strobes that drive an external minutes counter directly.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int SEC_MAX  = SEC_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    stopwatch_if.slave bus
);
    localparam logic [SEC_W-1:0] SEC_TERM = SEC_W'(SEC_MAX);

    state_e           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             sec_tick_q, sec_tick_d;
    logic             min_en_q, min_en_d;
    logic             min_clr_q, min_clr_d;
    logic             running_q, running_d;
    logic             run_en, tc, inc;

    assign run_en = (state_q == RUNNING);

    // The prescaler advances on every RUNNING cycle, including the one that
    // receives the pause pulse, so pause/resume never loses a cycle.
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (bus.clear),
        .tc_o (tc)
    );

    assign inc = tc && !bus.clear;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.clear && bus.start_stop) state_d = RUNNING;
            RUNNING: if (bus.clear)                    state_d = IDLE;
                     else if (bus.start_stop)          state_d = PAUSED;
            PAUSED:  if (bus.clear)                    state_d = IDLE;
                     else if (bus.start_stop)          state_d = RUNNING;
            default:                                   state_d = IDLE;
        endcase

        sec_d = sec_q;
        if (bus.clear)
            sec_d = '0;
        else if (inc)
            sec_d = (sec_q == SEC_TERM) ? '0 : sec_q + SEC_W'(1);

        sec_tick_d = inc;
        min_en_d   = inc && (sec_q == SEC_TERM);
        min_clr_d  = bus.clear;
        running_d  = (state_d == RUNNING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            sec_tick_q <= 1'b0;
            min_en_q   <= 1'b0;
            min_clr_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            sec_tick_q <= sec_tick_d;
            min_en_q   <= min_en_d;
            min_clr_q  <= min_clr_d;
            running_q  <= running_d;
        end
    end

    assign bus.seconds  = sec_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.min_en   = min_en_q;
    assign bus.min_clr  = min_clr_q;
    assign bus.running  = running_q;
endmodule
